// File: rtl/zic_priority_arbiter.sv
// ZIC priority arbiter: picks the highest-priority eligible pending source and
// runs a single-level request / claim / end-of-interrupt handshake with the core.
module zic_priority_arbiter #(
    parameter int NUM_SRC     = 48,
    parameter int PRIO_W      = 3,
    parameter int ID_BASE     = 16,
    parameter int ACK_TIMEOUT = 256
) (
    input  logic                      zic_clk,
    input  logic                      zic_rst,
    input  logic                      wdt_reset_i,
    input  logic [NUM_SRC-1:0]        interrupt_pending_i,
    input  logic                      interrupt_pending_valid_i,
    input  logic [NUM_SRC*PRIO_W-1:0] int_priority_i,
    input  logic [PRIO_W-1:0]         int_threshold_i,
    output logic                      irq_o,
    output logic [7:0]                irq_id_o,
    input  logic                      ack_i,
    input  logic [7:0]                ack_id_i,
    input  logic                      eoi_i,
    output logic                      in_service_o,
    output logic [7:0]                in_service_id_o,
    output logic                      ack_timeout_o
);

    localparam int TW = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t              state_q, state_d;
    logic                cand_valid_q;
    logic [7:0]          cand_id_q;
    logic [PRIO_W-1:0]   cand_prio_q;
    logic                win_found;
    logic [7:0]          win_idx;
    logic [PRIO_W-1:0]   win_prio;
    logic [TW-1:0]       timer_q, timer_d;
    logic                irq_d, in_service_d, ack_timeout_d, cur_pending;
    logic [7:0]          irq_id_d, in_service_id_d;

    // Strictly-greater comparison keeps the lowest index on priority ties.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_prio  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (interrupt_pending_i[k] && interrupt_pending_valid_i &&
                (int_priority_i[k*PRIO_W +: PRIO_W] > int_threshold_i) &&
                (!win_found || (int_priority_i[k*PRIO_W +: PRIO_W] > win_prio))) begin
                win_found = 1'b1;
                win_idx   = 8'(k);
                win_prio  = int_priority_i[k*PRIO_W +: PRIO_W];
            end
        end
    end

    always_comb begin
        cur_pending = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (irq_id_o == 8'(ID_BASE + k)) cur_pending = interrupt_pending_i[k];
        end
    end

    always_comb begin
        state_d         = state_q;
        irq_d           = irq_o;
        irq_id_d        = irq_id_o;
        timer_d         = timer_q;
        in_service_d    = in_service_o;
        in_service_id_d = in_service_id_o;
        ack_timeout_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cand_valid_q && (cand_prio_q != '0)) begin
                    irq_d    = 1'b1;
                    irq_id_d = cand_id_q;
                    timer_d  = '0;
                    state_d  = REQ;
                end
            end
            REQ: begin
                // Claim beats withdrawal so a same-edge receive-stage ack mask is harmless.
                if (ack_i && (ack_id_i == irq_id_o)) begin
                    irq_d           = 1'b0;
                    in_service_d    = 1'b1;
                    in_service_id_d = irq_id_o;
                    state_d         = SERVICE;
                end else if (!cur_pending) begin
                    irq_d   = 1'b0;
                    state_d = IDLE;
                end else if ((ACK_TIMEOUT != 0) && (timer_q == TIMER_LAST)) begin
                    irq_d         = 1'b0;
                    ack_timeout_d = 1'b1;
                    state_d       = IDLE;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            SERVICE: begin
                if (eoi_i) begin
                    in_service_d    = 1'b0;
                    in_service_id_d = '0;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge zic_clk or negedge zic_rst) begin
        if (!zic_rst) begin
            cand_valid_q    <= 1'b0;
            cand_id_q       <= '0;
            cand_prio_q     <= '0;
            state_q         <= IDLE;
            timer_q         <= '0;
            irq_o           <= 1'b0;
            irq_id_o        <= '0;
            in_service_o    <= 1'b0;
            in_service_id_o <= '0;
            ack_timeout_o   <= 1'b0;
        end else if (wdt_reset_i) begin
            cand_valid_q    <= 1'b0;
            cand_id_q       <= '0;
            cand_prio_q     <= '0;
            state_q         <= IDLE;
            timer_q         <= '0;
            irq_o           <= 1'b0;
            irq_id_o        <= '0;
            in_service_o    <= 1'b0;
            in_service_id_o <= '0;
            ack_timeout_o   <= 1'b0;
        end else begin
            cand_valid_q    <= win_found;
            cand_id_q       <= win_found ? (win_idx + 8'(ID_BASE)) : 8'd0;
            cand_prio_q     <= win_found ? win_prio : '0;
            state_q         <= state_d;
            timer_q         <= timer_d;
            irq_o           <= irq_d;
            irq_id_o        <= irq_id_d;
            in_service_o    <= in_service_d;
            in_service_id_o <= in_service_id_d;
            ack_timeout_o   <= ack_timeout_d;
        end
    end

endmodule

// File: doc/zic_priority_arbiter.md
Name: zic_priority_arbiter

Overview:
Downstream stage of the ZIC interrupt-receive block. It consumes the registered 48-bit pending vector and selects the highest-priority eligible source, ranked by per-source priority against a global threshold. It raises a single level request with an 8-bit ID (16..63) to the core and tracks one in-service interrupt until end-of-interrupt. The core's ack_i/ack_id_i are the same signals fed back to the receive stage.

Parameters:
NUM_SRC, 48, number of external sources.
PRIO_W, 3, priority field width per source; 0 = never eligible.
ID_BASE, 16, interrupt ID of source 0; source k maps to ID_BASE+k.
ACK_TIMEOUT, 256, REQ cycles without ack before the request is dropped; 0 disables the timeout.

Ports:
zic_clk  in  1  clock
zic_rst  in  1  asynchronous active-low reset
wdt_reset_i  in  1  synchronous clear, same effect as reset
interrupt_pending_i  in  48  pending vector from the receive stage
interrupt_pending_valid_i  in  1  pending vector valid
int_priority_i  in  144  flat priorities; bits [3k+2:3k] belong to source k
int_threshold_i  in  3  only priorities strictly greater than this are eligible
irq_o  out  1  interrupt request to core (level)
irq_id_o  out  8  ID of the requested interrupt; stable while irq_o=1
ack_i  in  1  core claim strobe
ack_id_i  in  8  ID being claimed
eoi_i  in  1  end-of-interrupt from core
in_service_o  out  1  an interrupt is claimed and not yet completed
in_service_id_o  out  8  ID in service
ack_timeout_o  out  1  one-cycle pulse when a request times out

Behaviour:
- Reset (async zic_rst=0) or wdt_reset_i=1 at an edge: every output, candidate register, timer and state go to 0 / IDLE. wdt_reset_i overrides all other inputs.
- Stage 1 (candidate register), updated every cycle:
  - eligible[k] = interrupt_pending_i[k] & (prio[k] > int_threshold_i) & interrupt_pending_valid_i.
  - The winner is the highest prio. Ties go to the lowest k.
  - Registers cand_valid_q, cand_id_q = ID_BASE+k (8-bit), cand_prio_q. If no source is eligible, cand_valid_q is 0.
- Latency: a pending bit sampled at edge E reaches cand at E. irq_o rises at E+1.
- FSM states: IDLE, REQ, SERVICE.
- IDLE:
  - If cand_valid_q: irq_o<=1, irq_id_o<=cand_id_q, timer<=0, go to REQ.
  - Otherwise stay.
- REQ:
  - irq_id_o is frozen. There is no re-arbitration, even if a higher-priority source arrives.
  - Claim: ack_i=1 and ack_id_i==irq_id_o. Then irq_o<=0, in_service_o<=1, in_service_id_o<=irq_id_o, go to SERVICE.
  - An ack with a mismatched ID is ignored.
  - Withdrawal: the pending bit for irq_id_o (the current input) is 0. Then irq_o<=0, go to IDLE.
  - Timeout: ACK_TIMEOUT≠0 and timer==ACK_TIMEOUT-1. Then irq_o<=0, ack_timeout_o<=1 for one cycle, go to IDLE. Otherwise timer increments (width clog2(ACK_TIMEOUT)+1, no wrap).
  - Precedence: claim > withdrawal > timeout.
- SERVICE:
  - irq_o=0 and no new request is issued (no nesting or preemption).
  - eoi_i=1: in_service_o<=0, in_service_id_o<=0, go to IDLE.
  - ack_i is ignored in this state. eoi_i is ignored in IDLE and REQ.
- The source is level-sensitive. If the same source is still pending after EOI, it is requested again: IDLE at EOI+1, irq_o at EOI+2.
- Interaction with the receive stage: its one-cycle ack mask may clear the pending bit at the claim edge. The claim still wins, per the precedence above.
- ack_timeout_o is 0 in every cycle except the single pulse.

Test Plan:
1. Basic flow:
   - Stimulus: source 5, prio 3, threshold 0, pending rises at edge E.
   - Response: irq_o=1 with irq_id_o=21 at E+1. ack_i with ID 21 gives irq_o=0, in_service_o=1, in_service_id_o=21 next edge. eoi_i returns the block to IDLE with in_service_o=0.
2. Priority and tie-break:
   - Sources 3 and 10 both at prio 4 → irq_id_o=19.
   - Source 10 at prio 6, source 3 at prio 4 → irq_id_o=26.
   - During REQ for 19, source 20 rises with prio 7 → irq_id_o stays 19 until claimed.
3. Threshold:
   - Source 0, prio 2, threshold 2 → irq_o stays 0 for 100 cycles.
   - Threshold changed to 1 → irq_o=1, irq_id_o=16 two edges later.
   - A source with prio 0 is never requested.
4. Timeout (ACK_TIMEOUT=256):
   - No ack → irq_o drops after 256 REQ cycles with a single-cycle ack_timeout_o.
   - Source still pending → irq_o rises again one edge later, same ID.
5. Handshake corners:
   - ack_id_i=22 while requesting 21 → ignored, irq_o stays 1.
   - Pending bit 5 drops in REQ → irq_o=0 next edge, no ack_timeout_o.
   - Ack and pending-drop on the same edge → SERVICE, in_service_id_o=21.
   - eoi_i asserted in IDLE → no effect.
6. Resets:
   - wdt_reset_i pulse in SERVICE → all outputs 0 at the next edge, FSM in IDLE.
   - zic_rst asserted asynchronously mid-REQ → irq_o=0 immediately, without waiting for a clock edge.
   - After reset release with a pending source → the request re-issues with correct 2-edge latency.
